// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one registered ALU between
// NUM_REQ requesters. Each operation runs IDLE -> EXEC -> RESP -> IDLE with
// valid/ready handshakes on both sides.
// Optional feature macro: ALU_ARB_TIMEOUT_EN. When it is defined, a response
// that is not accepted within TIMEOUT cycles is dropped and err_timeout pulses.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4,
    parameter int ALU_LAT = 1,
    parameter int TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2,
    input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W:0]           rsp_result,
    output logic                      rsp_carry,
    output logic                      rsp_zero,
    output logic [DATA_W-1:0]         alu_op1,
    output logic [DATA_W-1:0]         alu_op2,
    output logic [OP_W-1:0]           alu_opcode,
    input  logic [DATA_W:0]           alu_result,
    input  logic                      alu_carry,
    input  logic                      alu_zero,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

`ifdef ALU_ARB_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    // Without the timeout feature the wait counter never expires, so RESP
    // waits for its handshake indefinitely and err_timeout stays low.
    localparam logic TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_gidx;
    logic [IDX_W-1:0]    r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [TO_W-1:0]     r_wait;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W:0]     r_rsp_result;
    logic                r_rsp_carry;
    logic                r_rsp_zero;
    logic [DATA_W-1:0]   r_alu_op1;
    logic [DATA_W-1:0]   r_alu_op2;
    logic [OP_W-1:0]     r_alu_opcode;
    logic                r_err;

    logic                w_found;
    logic [IDX_W-1:0]    w_gidx;
    logic                w_accept;
    logic                w_capture;
    logic                w_rsp_hs;
    logic                w_expired;
    logic                w_drop;
    logic                w_release;
    int                  v_cand;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = {IDX_W{1'b0}};
        v_cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_cand = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && req_valid[v_cand]) begin
                w_found = 1'b1;
                w_gidx  = IDX_W'(v_cand);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Only the granted requester's ready goes high, and only while idle.
    assign req_ready = (r_state == ST_IDLE && w_found)
                     ? (NUM_REQ'(1'b1) << w_gidx) : {NUM_REQ{1'b0}};

    // Response handshake counts only for the granted requester.
    assign w_rsp_hs  = r_rsp_valid[r_gidx] & rsp_ready[r_gidx];
    assign w_expired = TO_EN & (r_wait == TO_W'(TIMEOUT - 1));
    assign w_release = w_rsp_hs | w_drop;

    // Next-state and control strobes of the IDLE/EXEC/RESP sequence.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next   = ST_EXEC;
                    w_accept = 1'b1;
                end else begin
                    w_next   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (r_cnt == CNT_W'(0)) begin
                    w_next    = ST_RESP;
                    w_capture = 1'b1;
                end else begin
                    w_next    = ST_EXEC;
                end
            end
            ST_RESP: begin
                // A handshake in the expiry cycle takes precedence over the drop.
                if (w_rsp_hs) begin
                    w_next = ST_IDLE;
                end else if (w_expired) begin
                    w_next = ST_IDLE;
                    w_drop = 1'b1;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the granted requester's operands and load the latency counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_gidx       <= {IDX_W{1'b0}};
            r_alu_op1    <= {DATA_W{1'b0}};
            r_alu_op2    <= {DATA_W{1'b0}};
            r_alu_opcode <= {OP_W{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_gidx       <= w_gidx;
            r_alu_op1    <= req_op1[w_gidx*DATA_W +: DATA_W];
            r_alu_op2    <= req_op2[w_gidx*DATA_W +: DATA_W];
            r_alu_opcode <= req_opcode[w_gidx*OP_W +: OP_W];
            r_cnt        <= CNT_W'(ALU_LAT);
        end else if (r_state == ST_EXEC && r_cnt != CNT_W'(0)) begin
            r_cnt        <= r_cnt - CNT_W'(1);
        end
    end

    // Capture the ALU outputs and present them until the response retires.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rsp_valid  <= {NUM_REQ{1'b0}};
            r_rsp_result <= {(DATA_W+1){1'b0}};
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid  <= NUM_REQ'(1'b1) << r_gidx;
            r_rsp_result <= alu_result;
            r_rsp_carry  <= alu_carry;
            r_rsp_zero   <= alu_zero;
        end else if (w_release) begin
            r_rsp_valid  <= {NUM_REQ{1'b0}};
        end
    end

    // Round-robin pointer moves only when an operation retires.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (w_release) begin
            r_last_grant <= r_gidx;
        end
    end

    // Response-wait counter and the one-cycle drop indication.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wait <= {TO_W{1'b0}};
            r_err  <= 1'b0;
        end else begin
            r_err <= w_drop;
            if (w_capture) begin
                r_wait <= {TO_W{1'b0}};
            end else if (r_state == ST_RESP && !w_expired) begin
                r_wait <= r_wait + TO_W'(1);
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_carry   = r_rsp_carry;
    assign rsp_zero    = r_rsp_zero;
    assign alu_op1     = r_alu_op1;
    assign alu_op2     = r_alu_op2;
    assign alu_opcode  = r_alu_opcode;
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = r_err;

endmodule
